// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default pixel width, 2x2 window lane
// indices and a lane slice helper used by the window generator and max-pool.
package cnn_pkg;

  localparam int DEF_DATA_W = 16;

  localparam int LANE_TL = 0;
  localparam int LANE_TR = 1;
  localparam int LANE_BL = 2;
  localparam int LANE_BR = 3;

  function automatic logic [DEF_DATA_W-1:0] window_lane(
    input logic [4*DEF_DATA_W-1:0] win,
    input int                      lane
  );
    return win[lane*DEF_DATA_W +: DEF_DATA_W];
  endfunction

endpackage

// File: rtl/pool_window_gen_if.sv
// Pixel-in / window-out bus between the raster source, the window
// generator and the max-pool consumer.
interface pool_window_gen_if
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic                en;
  logic                pix_valid;
  logic [DATA_W-1:0]   pix_in;
  logic [4*DATA_W-1:0] window_out;
  logic                window_valid;
  logic                frame_done;

  modport master (
    output en, pix_valid, pix_in,
    input  window_out, window_valid, frame_done
  );

  modport slave (
    input  en, pix_valid, pix_in,
    output window_out, window_valid, frame_done
  );

endinterface

// File: rtl/pool_window_gen_line_buffer.sv
// One-row pixel store: synchronous write, combinational read, intended for
// distributed RAM.
module line_buffer #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 28,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pool_window_gen.sv
// Raster-order pixel stream to non-overlapping 2x2 windows (stride 2) for
// the max-pool stage, with end-of-frame flag on the last window.
module pool_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input logic              clk,
  input logic              rst,
  pool_window_gen_if.slave pw
);

  if ((IMG_W % 2) != 0 || IMG_W < 2 || (IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_dims
    $fatal(1, "pool_window_gen: IMG_W and IMG_H must be even and >= 2");
  end

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]       col_cnt;
  logic [RW-1:0]       row_cnt;
  logic [DATA_W-1:0]   left_p0;
  logic [DATA_W-1:0]   top_left_p0;
  logic [DATA_W-1:0]   lb_rdata;
  logic [4*DATA_W-1:0] win_next;
  logic                accept;
  logic                col_last;
  logic                row_last;
  logic                odd_row;
  logic                odd_col;

  assign accept   = pw.en && pw.pix_valid;
  assign col_last = (col_cnt == CW'(IMG_W - 1));
  assign row_last = (row_cnt == RW'(IMG_H - 1));
  assign odd_row  = row_cnt[0];
  assign odd_col  = col_cnt[0];

  // Even rows fill the buffer; odd rows read back the same column address.
  line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_line_buffer (
    .clk   (clk),
    .we    (accept && !odd_row),
    .waddr (col_cnt),
    .wdata (pw.pix_in),
    .raddr (col_cnt),
    .rdata (lb_rdata)
  );

  always_comb begin
    win_next = '0;
    win_next[LANE_TL*DATA_W +: DATA_W] = top_left_p0;
    win_next[LANE_TR*DATA_W +: DATA_W] = lb_rdata;
    win_next[LANE_BL*DATA_W +: DATA_W] = left_p0;
    win_next[LANE_BR*DATA_W +: DATA_W] = pw.pix_in;
  end

  // Stage p0: left half of the window captured on odd-row, even-column pixels.
  always_ff @(posedge clk) begin
    if (accept && odd_row && !odd_col) top_left_p0 <= lb_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt         <= '0;
      row_cnt         <= '0;
      left_p0         <= '0;
      pw.window_out   <= '0;
      pw.window_valid <= 1'b0;
      pw.frame_done   <= 1'b0;
    end else if (!pw.en) begin
      col_cnt         <= '0;
      row_cnt         <= '0;
      left_p0         <= '0;
      pw.window_out   <= '0;
      pw.window_valid <= 1'b0;
      pw.frame_done   <= 1'b0;
    end else begin
      pw.window_valid <= 1'b0;
      pw.frame_done   <= 1'b0;
      if (pw.pix_valid) begin
        col_cnt <= col_last ? '0 : col_cnt + 1'b1;
        if (col_last) row_cnt <= row_last ? '0 : row_cnt + 1'b1;
        if (odd_row && !odd_col) left_p0 <= pw.pix_in;
        // Stage p1: bottom-right pixel completes the window.
        if (odd_row && odd_col) begin
          pw.window_out   <= win_next;
          pw.window_valid <= 1'b1;
          pw.frame_done   <= row_last && col_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_window_gen.sv
// Directed and random checks of pool_window_gen on a 4x4 and a 28x28 instance
// against a frame-array reference model and a max-pool reference.
module tb_pool_window_gen;
  import cnn_pkg::*;

  typedef struct {
    logic [63:0] w;
    logic        fd;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;
  int pulses_s = 0;
  int pulses_b = 0;
  int fd_b     = 0;
  int mark;

  exp_t q_s[$];
  exp_t q_b[$];
  exp_t es, eb;

  logic [15:0] fs [4][4];
  logic [15:0] fb [28][28];
  int sr = 0, sc = 0, br = 0, bc = 0;

  pool_window_gen_if #(.DATA_W(16)) if_s ();
  pool_window_gen_if #(.DATA_W(16)) if_b ();

  pool_window_gen #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) u_small (
    .clk (clk), .rst (rst), .pw (if_s.slave)
  );

  pool_window_gen #(.DATA_W(16)) u_big (
    .clk (clk), .rst (rst), .pw (if_b.slave)
  );

  function automatic logic [15:0] max4(input logic [63:0] w);
    logic [15:0] m;
    m = window_lane(w, LANE_TL);
    if (window_lane(w, LANE_TR) > m) m = window_lane(w, LANE_TR);
    if (window_lane(w, LANE_BL) > m) m = window_lane(w, LANE_BL);
    if (window_lane(w, LANE_BR) > m) m = window_lane(w, LANE_BR);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_s(input logic [15:0] v);
    exp_t e;
    if_s.pix_in    = v;
    if_s.pix_valid = 1'b1;
    fs[sr][sc] = v;
    if ((sr % 2) == 1 && (sc % 2) == 1) begin
      e.w   = {v, fs[sr][sc-1], fs[sr-1][sc], fs[sr-1][sc-1]};
      e.fd  = (sr == 3 && sc == 3);
      e.due = cyc + 1;
      q_s.push_back(e);
    end
    sc++;
    if (sc == 4) begin sc = 0; sr = (sr + 1) % 4; end
    step();
  endtask

  task automatic send_b(input logic [15:0] v);
    exp_t e;
    if_b.pix_in    = v;
    if_b.pix_valid = 1'b1;
    fb[br][bc] = v;
    if ((br % 2) == 1 && (bc % 2) == 1) begin
      e.w   = {v, fb[br][bc-1], fb[br-1][bc], fb[br-1][bc-1]};
      e.fd  = (br == 27 && bc == 27);
      e.due = cyc + 1;
      q_b.push_back(e);
    end
    bc++;
    if (bc == 28) begin bc = 0; br = (br + 1) % 28; end
    step();
  endtask

  task automatic idle_s(input int n);
    if_s.pix_valid = 1'b0;
    repeat (n) step();
  endtask

  // Scoreboard: pop and compare on every window pulse, away from the clock edge.
  always @(negedge clk) begin
    if (if_s.window_valid) begin
      pulses_s++;
      total++;
      assert (q_s.size() != 0) else begin
        bad++;
        $error("FAIL s_unexpected_window: observed=%h expected=none", if_s.window_out);
      end
      if (q_s.size() != 0) begin
        es = q_s.pop_front();
        total++;
        assert (if_s.window_out === es.w && if_s.frame_done === es.fd && cyc == es.due) else begin
          bad++;
          $error("FAIL s_window: observed=%h fd=%b cyc=%0d expected=%h fd=%b cyc=%0d",
                 if_s.window_out, if_s.frame_done, cyc, es.w, es.fd, es.due);
        end
      end
    end
    if (if_s.frame_done) begin
      total++;
      assert (if_s.window_valid === 1'b1) else begin
        bad++;
        $error("FAIL s_fd_without_valid: observed=%b expected=1", if_s.window_valid);
      end
    end
    if (if_b.window_valid) begin
      pulses_b++;
      if (if_b.frame_done) fd_b++;
      total++;
      assert (q_b.size() != 0) else begin
        bad++;
        $error("FAIL b_unexpected_window: observed=%h expected=none", if_b.window_out);
      end
      if (q_b.size() != 0) begin
        eb = q_b.pop_front();
        total++;
        assert (if_b.window_out === eb.w && if_b.frame_done === eb.fd && cyc == eb.due) else begin
          bad++;
          $error("FAIL b_window: observed=%h fd=%b cyc=%0d expected=%h fd=%b cyc=%0d",
                 if_b.window_out, if_b.frame_done, cyc, eb.w, eb.fd, eb.due);
        end
        total++;
        assert (max4(if_b.window_out) === max4(eb.w)) else begin
          bad++;
          $error("FAIL b_maxpool: observed=%h expected=%h", max4(if_b.window_out), max4(eb.w));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    if_s.en = 1'b1; if_s.pix_valid = 1'b0; if_s.pix_in = '0;
    if_b.en = 1'b1; if_b.pix_valid = 1'b0; if_b.pix_in = '0;
    step();
    step();
    chk("reset_s_window", if_s.window_out, 64'd0);
    chk("reset_s_flags", {62'd0, if_s.window_valid, if_s.frame_done}, 64'd0);
    chk("reset_b_window", if_b.window_out, 64'd0);
    rst = 1'b0;
    step();

    // 1: back-to-back 1..16
    mark = pulses_s;
    for (int i = 1; i <= 16; i++) begin
      send_s(16'(i));
      if (i == 6)  chk("t1_win_p6",  if_s.window_out, 64'h0006_0005_0002_0001);
      if (i == 8)  chk("t1_win_p8",  if_s.window_out, 64'h0008_0007_0004_0003);
      if (i == 14) chk("t1_win_p14", if_s.window_out, 64'h000E_000D_000A_0009);
      if (i == 16) begin
        chk("t1_win_p16", if_s.window_out, 64'h0010_000F_000C_000B);
        chk("t1_fd_p16",  {63'd0, if_s.frame_done}, 64'd1);
      end
    end
    idle_s(2);
    chk("t1_pulses", 64'(pulses_s - mark), 64'd4);

    // 2: three idle cycles after every pixel
    mark = pulses_s;
    for (int i = 1; i <= 16; i++) begin
      send_s(16'(i));
      idle_s(3);
    end
    chk("t2_pulses", 64'(pulses_s - mark), 64'd4);
    chk("t2_hold", if_s.window_out, 64'h0010_000F_000C_000B);

    // 3: two frames back-to-back
    mark = pulses_s;
    for (int i = 0; i < 32; i++) begin
      send_s((i < 16) ? 16'(1 + i) : 16'(101 + i - 16));
      if (i == 21) chk("t3_f2_first", if_s.window_out, 64'h006A_0069_0066_0065);
    end
    idle_s(2);
    chk("t3_pulses", 64'(pulses_s - mark), 64'd8);

    // 4: reset mid-frame after pixel 7
    for (int i = 1; i <= 7; i++) send_s(16'(i));
    if_s.pix_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t4_rst_window", if_s.window_out, 64'd0);
    step();
    step();
    chk("t4_rst_flags", {62'd0, if_s.window_valid, if_s.frame_done}, 64'd0);
    rst = 1'b0;
    sr = 0; sc = 0;
    chk("t4_queue_empty", 64'(q_s.size()), 64'd0);
    mark = pulses_s;
    for (int i = 1; i <= 16; i++) begin
      send_s(16'(i));
      if (i == 6) chk("t4_first_win", if_s.window_out, 64'h0006_0005_0002_0001);
    end
    idle_s(2);
    chk("t4_pulses", 64'(pulses_s - mark), 64'd4);

    // 5: en low for one cycle after pixel 10, with pix_valid high
    for (int i = 1; i <= 10; i++) send_s(16'(i));
    if_s.en = 1'b0;
    if_s.pix_valid = 1'b1;
    if_s.pix_in = 16'd99;
    step();
    chk("t5_en_window", if_s.window_out, 64'd0);
    chk("t5_en_flags", {62'd0, if_s.window_valid, if_s.frame_done}, 64'd0);
    if_s.en = 1'b1;
    sr = 0; sc = 0;
    mark = pulses_s;
    for (int i = 1; i <= 16; i++) begin
      send_s(16'(i));
      if (i == 6) chk("t5_first_win", if_s.window_out, 64'h0006_0005_0002_0001);
    end
    idle_s(2);
    chk("t5_pulses", 64'(pulses_s - mark), 64'd4);

    // 6: default 28x28 frame, random pixels with occasional gaps
    for (int i = 0; i < 28 * 28; i++) begin
      send_b(16'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        if_b.pix_valid = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
    end
    if_b.pix_valid = 1'b0;
    repeat (3) step();
    chk("t6_pulses", 64'(pulses_b), 64'd196);
    chk("t6_frame_done", 64'(fd_b), 64'd1);
    chk("t6_queue_empty", 64'(q_b.size()), 64'd0);
    chk("end_s_queue_empty", 64'(q_s.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
- Upstream neighbour of the 2x2 max-pool stage.
- Accepts one feature-map pixel per valid cycle, in row-major raster order.
- Buffers one image row and emits a packed 2x2 window (stride 2, non-overlapping) as a 64-bit word with a one-cycle valid pulse. The max-pool combinational comparator consumes this word directly.
- Also tracks row/column position and flags end of frame.

Parameters:
- DATA_W, 16, pixel width in bits. Packed window is 4*DATA_W.
- IMG_W, 28, feature-map width in pixels. Must be even and >= 2.
- IMG_H, 28, feature-map height in pixels. Must be even and >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  block enable. Low = synchronous clear of counters and outputs.
- pix_valid  input  1  pix_in valid this cycle.
- pix_in  input  DATA_W  input pixel.
- window_out  output  4*DATA_W  packed window: [DATA_W-1:0]=top-left, [2*DATA_W-1:DATA_W]=top-right, [3*DATA_W-1:2*DATA_W]=bottom-left, [4*DATA_W-1:3*DATA_W]=bottom-right.
- window_valid  output  1  one-cycle pulse, window_out is valid.
- frame_done  output  1  one-cycle pulse with the last window of a frame.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (rst).
- While rst is high:
  - window_out=0, window_valid=0, frame_done=0.
  - col_cnt=0, row_cnt=0, left-pixel register=0.
  - Line-buffer memory is not reset. Its contents are don't-care until rewritten.
- en low (sampled at the clock edge) has the same effect as reset on counters and outputs. pix_valid is ignored while en is low.
- Counters:
  - col_cnt (0..IMG_W-1) increments on each accepted pixel, where accepted = en && pix_valid. It wraps to 0 after IMG_W-1.
  - row_cnt increments when col_cnt wraps. It wraps to 0 after IMG_H-1, then the next frame starts with no gap cycle.
- Even rows (row_cnt[0]=0): each accepted pixel is written to line_buf[col_cnt]. No output.
- Odd rows, even columns: pixel captured into left register; line_buf[col_cnt] read into top-left register.
- Odd rows, odd columns, registered at the accepting clock edge:
  - window_out <= {pix_in, left_reg, line_buf[col_cnt], top_left_reg}.
  - window_valid <= 1.
- Latency: window_valid is high in the cycle after the bottom-right pixel is accepted.
- window_out holds its last value when window_valid is low. It is cleared only by rst or en low.
- frame_done <= 1 together with window_valid when the accepted pixel is at row IMG_H-1, col IMG_W-1.
- Window rate: (IMG_W/2)*(IMG_H/2) windows per frame.
- Gaps on pix_valid: no state changes, window_valid=0. Gaps may occur anywhere, including between a row's last pixel and the next row.
- No backpressure. The consumer must accept every window_valid pulse.
- Reset or en low mid-frame: the partial frame is abandoned. The next accepted pixel is treated as (row 0, col 0).
- Line buffer read during odd rows uses the same address written in the previous even row. No read/write collision is possible because reads and writes are row-exclusive.
- Pixel values are unsigned and passed through unmodified. No arithmetic.
- Elaboration: fatal error if IMG_W or IMG_H is odd or < 2.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_W default.
  - Window lane indices: LANE_TL=0, LANE_TR=1, LANE_BL=2, LANE_BR=3.
  - A window slice helper.
- The max-pool stage and this block both use these lane indices.
- One sub-module: line_buffer.
  - IMG_W x DATA_W memory with synchronous write and combinational read.
  - Ports: clk, we, waddr, wdata, raddr, rdata.
  - Maps to distributed RAM.
- Counters and window assembly stay in pool_window_gen.

Test Plan:
1. IMG_W=4, IMG_H=4, pixels 1..16 back-to-back. window_out must be:
   - 0x0006_0005_0002_0001 one cycle after pixel 6.
   - 0x0008_0007_0004_0003 after pixel 8.
   - 0x000E_000D_000A_0009 after pixel 14.
   - 0x0010_000F_000C_000B after pixel 16, with frame_done=1.
   - Exactly 4 window_valid pulses.
2. Same frame with pix_valid low for 3 cycles after every pixel. Same 4 windows in the same order; each window_valid is a single-cycle pulse.
3. Two frames back-to-back: 1..16, then 101..116. Second frame's first window is 0x006A_0069_0066_0065 (106,105,102,101), with no cross-frame contamination.
4. Assert rst for 2 cycles after pixel 7, then send 1..16. Outputs read 0 during reset; the first window after reset is 0x0006_0005_0002_0001.
5. Drop en low for 1 cycle after pixel 10, then send 1..16. The window at pixel 6 of the new stream is 0x0006_0005_0002_0001. pix_valid high while en is low produces no window.
6. Default 28x28 frame with random 16-bit pixels. The scoreboard matches all 196 windows, and a max-pool reference model matches.
